// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - signed MULT/DIV sequencer writing HI/LO for the multicycle MIPS core
// Optional MULDIV_EARLY_TERM_EN: zero-operand operations skip the iteration phase.
module muldiv_sequencer #(
  parameter int W     = 32,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         div0,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state;
  logic [W:0]       rem_r;
  logic [W-1:0]     quo_r;
  logic [W:0]       opr;
  logic             sign_a, sign_b, op_r;
  logic [CNT_W-1:0] count;

  logic [W:0]       mag_a, mag_b;
  logic [W+1:0]     mul_sum;
  logic [W:0]       div_sh, div_diff;
  logic             div_ge;
  logic [2*W-1:0]   prod_mag, prod_s;
  logic [W-1:0]     quo_s, rem_s;
  logic             early;

  // Magnitudes carry one extra bit so |-2^(W-1)| is representable.
  assign mag_a = a[W-1] ? -{a[W-1], a} : {1'b0, a};
  assign mag_b = b[W-1] ? -{b[W-1], b} : {1'b0, b};

  // rem_r is the product's upper half for MULT and the partial remainder for DIV.
  assign mul_sum  = {1'b0, rem_r} + (quo_r[0] ? {1'b0, opr} : '0);
  assign div_sh   = {rem_r[W-1:0], quo_r[W-1]};
  assign div_ge   = (div_sh >= opr);
  assign div_diff = div_sh - opr;

  assign prod_mag = {rem_r[W-1:0], quo_r};
  assign prod_s   = (sign_a ^ sign_b) ? -prod_mag : prod_mag;
  assign quo_s    = (sign_a ^ sign_b) ? -quo_r : quo_r;
  assign rem_s    = sign_a ? -rem_r[W-1:0] : rem_r[W-1:0];

`ifdef MULDIV_EARLY_TERM_EN
  assign early = op ? (a == '0) : ((a == '0) || (b == '0));
`else
  assign early = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      rem_r  <= '0;
      quo_r  <= '0;
      opr    <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      op_r   <= 1'b0;
      count  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      div0   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      div0 <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (op && (b == '0)) begin
              div0 <= 1'b1;
            end else begin
              sign_a <= a[W-1];
              sign_b <= b[W-1];
              op_r   <= op;
              count  <= '0;
              rem_r  <= '0;
              opr    <= op ? mag_b : mag_a;
              quo_r  <= early ? '0 : (op ? mag_a[W-1:0] : mag_b[W-1:0]);
              busy   <= 1'b1;
              state  <= early ? FIN : RUN;
            end
          end
        end
        RUN: begin
          if (op_r) begin
            rem_r <= div_ge ? div_diff : div_sh;
            quo_r <= {quo_r[W-2:0], div_ge};
          end else begin
            rem_r <= mul_sum[W+1:1];
            quo_r <= {mul_sum[0], quo_r[W-1:1]};
          end
          count <= count + 1'b1;
          if (count == CNT_W'(W - 1)) state <= FIN;
        end
        FIN: begin
          if (op_r) begin
            hi <= rem_s;
            lo <= quo_s;
          end else begin
            hi <= prod_s[2*W-1:W];
            lo <= prod_s[W-1:0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - randomized bench for muldiv_sequencer against an arithmetic model
module tb_muldiv_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, op;
  logic [W-1:0] a, b;
  logic         busy, done, div0;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.W(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; b2b returns in the done cycle so the next call overlaps it.
  task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit repulse, input bit b2b);
    longint sx, sy, p, q, r;
    logic [63:0] pv;
    logic [W-1:0] exp_hi, exp_lo;
    int n, busy_n, div0_n, done_n, exp_lat;
    bit zdiv;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    zdiv = o && (y == '0);
    exp_hi = model_hi;
    exp_lo = model_lo;
    if (!zdiv) begin
      if (o) begin
        q = sx / sy;
        r = sx % sy;
        exp_lo = q[W-1:0];
        exp_hi = r[W-1:0];
      end else begin
        p = sx * sy;
        pv = p;
        exp_hi = pv[2*W-1:W];
        exp_lo = pv[W-1:0];
      end
    end
    exp_lat = W + 1;
`ifdef MULDIV_EARLY_TERM_EN
    if ((x == '0) || (!o && y == '0)) exp_lat = 1;
`endif
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = $urandom; a = $urandom; b = $urandom;
    if (zdiv) begin
      check_eq("div0_pulse", div0, 1'b1);
      check_eq("div0_busy", busy, 1'b0);
      check_eq("div0_done", done, 1'b0);
      check_eq("div0_hi", hi, model_hi);
      check_eq("div0_lo", lo, model_lo);
      @(negedge clk);
      check_eq("div0_width", div0, 1'b0);
      check_eq("div0_nodone", done, 1'b0);
      return;
    end
    n = 0; busy_n = 0; div0_n = 0;
    while (!done && n < 200) begin
      if (busy) busy_n++;
      if (div0) div0_n++;
      if (n == 3 && exp_lat > 3) begin
        check_eq("hold_hi", hi, model_hi);
        check_eq("hold_lo", lo, model_lo);
      end
      if (repulse) start = (n >= 2 && n <= 6);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check_eq("latency", n, exp_lat);
    check_eq("busy_cycles", busy_n, exp_lat);
    check_eq("no_div0", div0_n, 0);
    check_eq("done_busy", busy, 1'b0);
    check_eq("done_div0", div0, 1'b0);
    check_eq("hi", hi, exp_hi);
    check_eq("lo", lo, exp_lo);
    model_hi = exp_hi;
    model_lo = exp_lo;
    if (b2b) return;
    @(negedge clk);
    check_eq("done_width", done, 1'b0);
    if (repulse) begin
      done_n = 0;
      repeat (W + 4) begin
        @(negedge clk);
        if (done || busy) done_n++;
      end
      check_eq("repulse_single", done_n, 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int done_n, sel;
    logic o;
    logic [W-1:0] x, y;
    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_div0", div0, 1'b0);
    check_eq("rst_hi", hi, 0);
    check_eq("rst_lo", lo, 0);
    reset = 1'b0;
    @(negedge clk);

    run_op(1'b0, 32'd7, -32'sd3, 0, 0);
    run_op(1'b1, -32'sd17, 32'd5, 0, 0);
    run_op(1'b1, 32'd100, 32'd0, 0, 0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 0, 0);

    // Abort an operation mid-iteration.
    start = 1'b1; op = 1'b0; a = 32'd12345; b = 32'd678;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_done", done, 1'b0);
    check_eq("abort_hi", hi, 0);
    check_eq("abort_lo", lo, 0);
    reset = 1'b0;
    model_hi = '0; model_lo = '0;
    done_n = 0;
    repeat (W + 5) begin
      @(negedge clk);
      if (done) done_n++;
    end
    check_eq("abort_nodone", done_n, 0);

    run_op(1'b0, 32'd12345, -32'sd678, 0, 0);
    run_op(1'b1, 32'd5, 32'd7, 1, 0);
    run_op(1'b0, 32'd0, 32'd9, 0, 0);
    run_op(1'b1, 32'd0, 32'd3, 0, 0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1);
    run_op(1'b1, 32'h7FFF_FFFF, -32'sd2, 0, 1);
    run_op(1'b1, -32'sd7, -32'sd2, 0, 0);

    for (int i = 0; i < 30; i++) begin
      o = 1'(($urandom_range(0, 1)));
      x = $urandom;
      y = $urandom;
      sel = $urandom_range(0, 5);
      if (sel == 0) y = '0;
      else if (sel == 1) begin x = $urandom_range(0, 40) - 20; y = $urandom_range(1, 9); end
      else if (sel == 2) begin x = 32'h8000_0000; y = (i % 2) ? 32'h8000_0000 : $urandom_range(1, 3); end
      else if (sel == 3) x = '0;
      run_op(o, x, y, (i % 7) == 3, (i % 5) == 1);
    end
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
